// File: rtl/left_shift_seq_pkg.sv
// Shared ALU shift-path definitions: FSM state encoding and default widths.
package left_shift_seq_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SHAMT_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    SHIFT_IDLE = 2'd0,
    SHIFT_RUN  = 2'd1,
    SHIFT_DONE = 2'd2
  } shift_state_e;

endpackage

// File: rtl/left_shift_seq_if.sv
// Request/result bundle between the ALU (master) and the iterative shifter (slave).
interface left_shift_seq_if
  import left_shift_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
);

  logic                   ctrl_start;
  logic [DATA_WIDTH-1:0]  data_operand;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  data_result;
  logic                   data_resultRDY;
  logic                   busy;

  modport master (
    output ctrl_start, data_operand, shamt,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_start, data_operand, shamt,
    output data_result, data_resultRDY, busy
  );

endinterface

// File: rtl/left_shift_seq_stage.sv
// One conditional power-of-two left shift; the iterative datapath reuses it for
// every shift-amount bit.
module left_shift_stage
  import left_shift_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0]  value,
  input  logic                   enable,
  input  logic [SHAMT_WIDTH-1:0] index,
  output logic [DATA_WIDTH-1:0]  shifted
);

  // Shift by 2**index when enabled; zeros enter at the LSB, overflow is dropped.
  always_comb begin
    // NOTE: default assignment first so no path leaves 'shifted' unassigned (no latch).
    shifted = value;
    if (enable) begin
      shifted = value << (32'd1 << index);
    end
  end

endmodule

// File: rtl/left_shift_seq.sv
// Multi-cycle logical left shifter: resolves one shift-amount bit per cycle,
// MSB first, then presents the result with a one-cycle ready pulse.
module left_shift_seq
  import left_shift_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  left_shift_seq_if.slave   bus
);

  if ((2 ** SHAMT_WIDTH) != DATA_WIDTH) begin : g_bad_width
    $error("left_shift_seq: 2**SHAMT_WIDTH must equal DATA_WIDTH");
  end

  localparam logic [SHAMT_WIDTH-1:0] LAST_STAGE = SHAMT_WIDTH'(SHAMT_WIDTH - 1);

  shift_state_e           state;
  logic [DATA_WIDTH-1:0]  acc;
  logic [SHAMT_WIDTH-1:0] shamt_q;
  logic [SHAMT_WIDTH-1:0] stage_idx;
  logic [DATA_WIDTH-1:0]  stage_out;
  logic                   accept;

  // A new request is taken when idle, or in the final cycle of the previous one
  // so the ALU can issue back-to-back shifts without a bubble.
  always_comb begin
    accept = bus.ctrl_start && ((state == SHIFT_IDLE) || (state == SHIFT_DONE));
  end

  left_shift_stage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_stage (
    .value   (acc),
    .enable  (shamt_q[stage_idx]),
    .index   (stage_idx),
    .shifted (stage_out)
  );

  // Control FSM, stage counter, accumulator and registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state              <= SHIFT_IDLE;
      acc                <= '0;
      shamt_q            <= '0;
      stage_idx          <= LAST_STAGE;
      bus.data_result    <= '0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;

      case (state)
        SHIFT_IDLE: begin
          // Wait for a request; the load itself is handled below.
        end

        SHIFT_RUN: begin
          acc <= stage_out;
          if (stage_idx == '0) begin
            state    <= SHIFT_DONE;
            bus.busy <= 1'b0;
          end else begin
            stage_idx <= stage_idx - 1'b1;
          end
        end

        SHIFT_DONE: begin
          // The result register only moves here, so it holds across later shifts.
          bus.data_result    <= acc;
          bus.data_resultRDY <= 1'b1;
          state              <= SHIFT_IDLE;
        end

        default: state <= SHIFT_IDLE;
      endcase

      // Latch operand and distance; later input changes cannot disturb the run.
      if (accept) begin
        acc       <= bus.data_operand;
        shamt_q   <= bus.shamt;
        stage_idx <= LAST_STAGE;
        state     <= SHIFT_RUN;
        bus.busy  <= 1'b1;
      end
    end
  end

endmodule
